// File: rtl/rs_drv_pkg.sv
// Shared encodings and helpers for the RS latch command driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs_drv_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } drv_state_t;

    // Latch inputs {R,S} for a command given the current Q; never both high.
    function automatic logic [1:0] rs_drive(input logic [1:0] op, input logic q);
        case (op)
            OP_SET:  return 2'b01;
            OP_RST:  return 2'b10;
            OP_TOG:  return q ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic q_after(input logic [1:0] op, input logic q);
        case (op)
            OP_SET:  return 1'b1;
            OP_RST:  return 1'b0;
            OP_TOG:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/rs_phase_timer.sv
// Loadable down-counter timing one latch phase; zero flags phase end.
// Latency: zero asserts load_val cycles after the load edge.
// Backpressure: none; load always wins over counting.
module rs_phase_timer
    import rs_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rs_latch_driver.sv
// Drives set/reset/toggle/hold commands into a gated RS latch and checks Q/Qn.
// Latency: done in the (SETUP_CYC+PULSE_CYC+HOLD_CYC+1)th cycle after accept.
// Backpressure: req_ready only in IDLE; requests while busy are not queued.
module rs_latch_driver
    import rs_drv_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       R,
    output logic       S,
    output logic       C,
    input  logic       Q,
    input  logic       Qn,
    output logic       busy,
    output logic       done,
    output logic       q_exp,
    output logic       err,
    output logic [7:0] err_cnt
);

    drv_state_t       state, state_nxt;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             r_q, s_q;

    assign accept = req_valid && (state == IDLE);

    rs_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timer is loaded with N-1 so each phase lasts exactly N cycles.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_nxt = PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_nxt = HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // R/S only move on accept and on leaving HOLD, so they are stable around C.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 1'b0;
            s_q   <= 1'b0;
            q_exp <= 1'b0;
        end else if (accept) begin
            {r_q, s_q} <= rs_drive(req_op, Q);
            q_exp      <= q_after(req_op, Q);
        end else if (state == HOLD && tmr_zero) begin
            r_q <= 1'b0;
            s_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (state == CHECK) begin
            err <= (Q != q_exp) || (Qn == Q);
            if (((Q != q_exp) || (Qn == Q)) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign R         = r_q;
    assign S         = s_q;
    assign C         = (state == PULSE);
    assign done      = (state == CHECK);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rs_latch_driver.sv
// Directed bench for rs_latch_driver with a behavioural gated RS latch model.
module tb_rs_latch_driver;
    import rs_drv_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready, R, S, C, Q, Qn, busy, done, q_exp, err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic lq     = 1'b0;
    logic stuck0 = 1'b0;
    logic qn_eq  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (C) begin
            if (S)      lq <= 1'b1;
            else if (R) lq <= 1'b0;
        end
    end
    assign Q  = stuck0 ? 1'b0 : lq;
    assign Qn = qn_eq ? Q : ~Q;

    rs_latch_driver #(
        .SETUP_CYC (2),
        .PULSE_CYC (4),
        .HOLD_CYC  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_ready (req_ready),
        .R         (R),
        .S         (S),
        .C         (C),
        .Q         (Q),
        .Qn        (Qn),
        .busy      (busy),
        .done      (done),
        .q_exp     (q_exp),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
        if (!req_ready) chk({tag, ".ready_timeout"}, 32'(req_ready), 1);
    endtask

    // Called at a negedge; returns at the negedge one cycle after done.
    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic exp_r, input logic exp_s,
                           input logic exp_q, input logic exp_err,
                           input logic [7:0] exp_cnt, input bit detail);
        int c_cnt, c_first, done_at, rs_ok, rs_bad, rdy_bad;
        c_cnt = 0; c_first = 0; done_at = 0; rs_ok = 0; rs_bad = 0; rdy_bad = 0;
        wait_ready(tag);
        req_valid = 1'b1;
        req_op    = op;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = OP_HOLD;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (C) begin
                c_cnt++;
                if (c_first == 0) c_first = i;
            end
            if (done && done_at == 0) done_at = i;
            if (i <= 8 && R == exp_r && S == exp_s) rs_ok++;
            if (i == 9 && (R || S)) rs_bad++;
            if (R && S) rs_bad++;
            if (req_ready || !busy) rdy_bad++;
        end
        @(negedge clk);
        if (detail) begin
            chk({tag, ".c_cycles"}, c_cnt, 4);
            chk({tag, ".c_first"}, c_first, 3);
            chk({tag, ".done_at"}, done_at, 9);
            chk({tag, ".rs_stable"}, rs_ok, 8);
            chk({tag, ".rs_illegal"}, rs_bad, 0);
            chk({tag, ".ready_busy"}, rdy_bad, 0);
            chk({tag, ".ready_after"}, 32'(req_ready), 1);
            chk({tag, ".done_after"}, 32'(done), 0);
        end
        chk({tag, ".q_exp"}, 32'(q_exp), 32'(exp_q));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, last, both, rdy_busy, done_seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_HOLD;
        @(negedge clk);
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 1);
        chk("rst.R", 32'(R), 0);
        chk("rst.S", 32'(S), 0);
        chk("rst.C", 32'(C), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.q_exp", 32'(q_exp), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd("set", OP_SET, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        chk("set.Q", 32'(Q), 1);
        run_cmd("tog1", OP_TOG, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("tog1.Q", 32'(Q), 0);
        run_cmd("tog2", OP_TOG, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        chk("tog2.Q", 32'(Q), 1);
        run_cmd("hold", OP_HOLD, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);

        stuck0 = 1'b1;
        run_cmd("stuck", OP_SET, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1);
        for (int k = 2; k <= 300; k++) begin
            run_cmd("stuck_n", OP_SET, 1'b0, 1'b1, 1'b1, 1'b1,
                    (k > 255) ? 8'd255 : 8'(k), 1'b0);
        end
        stuck0 = 1'b0;

        qn_eq = 1'b1;
        run_cmd("hold_qn", OP_HOLD, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
        qn_eq = 1'b0;

        // Abort in the middle of the C pulse.
        wait_ready("mid");
        req_valid = 1'b1;
        req_op    = OP_SET;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        chk("mid.C_before", 32'(C), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.C", 32'(C), 0);
        chk("mid.R", 32'(R), 0);
        chk("mid.S", 32'(S), 0);
        chk("mid.busy", 32'(busy), 0);
        chk("mid.done", 32'(done), 0);
        chk("mid.req_ready", 32'(req_ready), 1);
        chk("mid.err_cnt", 32'(err_cnt), 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("mid.no_done", done_seen, 0);

        // req_valid held high with alternating set/reset.
        acc = 0; last = -1; both = 0; rdy_busy = 0;
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (R && S) both++;
            if (req_ready && busy) rdy_busy++;
            if (req_ready) begin
                if (last >= 0) chk("b2b.gap", cyc - last, 10);
                last   = cyc;
                req_op = acc[0] ? OP_RST : OP_SET;
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b.accepts", acc, 5);
        chk("b2b.r_and_s", both, 0);
        chk("b2b.ready_busy", rdy_busy, 0);
        wait_ready("b2b");
        chk("b2b.q_exp", 32'(q_exp), 1);
        chk("b2b.err", 32'(err), 0);
        chk("b2b.err_cnt", 32'(err_cnt), 0);
        chk("b2b.Q", 32'(Q), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
